vram_wr_arbiter: RTL

Shares the single VRAM write port between CPU stores, which arrive from the bus decoder's `vram_we`/`vram_addr`/`vram_data` at the 0xC region, and a hardware rectangle-free linear fill engine used for screen clears. CPU writes are buffered in a small FIFO so that they are not lost while the fill engine or the display side holds the port. The block sits between the bus decoder and the VRAM write port.

---
 rtl/vram_arb_pkg.sv | 26 ++
 rtl/vram_wr_arbiter_if.sv | 34 +++
 rtl/vram_wr_fifo.sv | 55 +++++
 rtl/vram_wr_arbiter.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/vram_arb_pkg.sv
// Shared types and widths for the VRAM write arbiter: pixel/address widths,
// fill FSM states, grant encoding and the buffered CPU write payload.
package vram_arb_pkg;

   localparam int unsigned VRAM_AW = 19;
   localparam int unsigned PIX_W   = 12;
   localparam int unsigned WR_W    = VRAM_AW + PIX_W;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } fill_state_e;

   typedef enum logic [1:0] {
      GNT_NONE = 2'd0,
      GNT_CPU  = 2'd1,
      GNT_FILL = 2'd2
   } gnt_e;

   typedef struct packed {
      logic [VRAM_AW-1:0] addr;
      logic [PIX_W-1:0]   data;
   } vram_wr_t;

endpackage

// File: rtl/vram_wr_arbiter_if.sv
// Bus bundle between the bus decoder / fill control and the VRAM write arbiter.
interface vram_wr_arbiter_if;
   import vram_arb_pkg::*;

   logic               cpu_we;
   logic [VRAM_AW-1:0] cpu_addr;
   logic [PIX_W-1:0]   cpu_data;
   logic               cpu_ready;
   logic               fill_start;
   logic [VRAM_AW-1:0] fill_base;
   logic [VRAM_AW-1:0] fill_len;
   logic [PIX_W-1:0]   fill_color;
   logic               fill_busy;
   logic               fill_done;
   logic               wr_ovf;
   logic               ovf_clr;
   logic               vram_stall;
   logic               vram_we;
   logic [VRAM_AW-1:0] vram_addr;
   logic [PIX_W-1:0]   vram_data;

   modport slave (
      input  cpu_we, cpu_addr, cpu_data, fill_start, fill_base, fill_len,
             fill_color, ovf_clr, vram_stall,
      output cpu_ready, fill_busy, fill_done, wr_ovf, vram_we, vram_addr, vram_data
   );

   modport master (
      output cpu_we, cpu_addr, cpu_data, fill_start, fill_base, fill_len,
             fill_color, ovf_clr, vram_stall,
      input  cpu_ready, fill_busy, fill_done, wr_ovf, vram_we, vram_addr, vram_data
   );

endinterface

// File: rtl/vram_wr_fifo.sv
// Synchronous FIFO for buffered CPU pixel writes; push ignored when full,
// pop ignored when empty; no write-through bypass.
module vram_wr_fifo
   import vram_arb_pkg::*;
#(
   parameter int unsigned DEPTH = 4
) (
   input  logic     clk,
   input  logic     rst,
   input  logic     i_push,
   input  vram_wr_t i_din,
   input  logic     i_pop,
   output vram_wr_t o_dout_c,
   output logic     o_full_c,
   output logic     o_empty_c
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   vram_wr_t           r_mem [DEPTH];
   logic [PTR_W-1:0]   r_wptr;
   logic [PTR_W-1:0]   r_rptr;
   logic [CNT_W-1:0]   r_count;
   logic               w_push;
   logic               w_pop;

   assign o_full_c  = (r_count == CNT_W'(DEPTH));
   assign o_empty_c = (r_count == '0);
   assign o_dout_c  = r_mem[r_rptr];
   assign w_push    = i_push & ~o_full_c;
   assign w_pop     = i_pop & ~o_empty_c;

   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wptr] <= i_din;
   end

   // Pointers wrap naturally since DEPTH is a power of two.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (w_push) r_wptr <= r_wptr + PTR_W'(1);
         if (w_pop)  r_rptr <= r_rptr + PTR_W'(1);
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CNT_W'(1);
            2'b01:   r_count <= r_count - CNT_W'(1);
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: rtl/vram_wr_arbiter.sv
// Shares the VRAM write port between buffered CPU stores and the linear fill engine.
// Define VRAM_ARB_RR_EN for round-robin arbitration; default is CPU fixed priority.
module vram_wr_arbiter
   import vram_arb_pkg::*;
#(
   parameter int unsigned FIFO_DEPTH = 4,
   parameter int unsigned VRAM_WORDS = 307200
) (
   input  logic               clk,
   input  logic               rst,
   vram_wr_arbiter_if.slave   bus
);

   fill_state_e        r_state, w_state_nxt;
   logic [VRAM_AW-1:0] r_fill_addr, w_fill_addr_nxt;
   logic [VRAM_AW-1:0] r_fill_rem, w_fill_rem_nxt;
   logic [PIX_W-1:0]   r_fill_color, w_fill_color_nxt;
   logic               r_fill_busy, w_fill_busy_nxt;
   logic               r_fill_done, w_fill_done_nxt;
   logic               r_vram_we;
   logic [VRAM_AW-1:0] r_vram_addr;
   logic [PIX_W-1:0]   r_vram_data;
   logic               r_wr_ovf;

   vram_wr_t           w_fifo_din, w_fifo_dout;
   logic               w_full, w_empty;
   logic               w_ovf_set;
   logic [VRAM_AW:0]   w_addr_inc;
   gnt_e               w_gnt;

   assign w_fifo_din = '{addr: bus.cpu_addr, data: bus.cpu_data};
   assign w_ovf_set  = bus.cpu_we & w_full;

   vram_wr_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .i_push    (bus.cpu_we),
      .i_din     (w_fifo_din),
      .i_pop     (w_gnt == GNT_CPU),
      .o_dout_c  (w_fifo_dout),
      .o_full_c  (w_full),
      .o_empty_c (w_empty)
   );

`ifdef VRAM_ARB_RR_EN
   // High means CPU wins the next contended cycle.
   logic r_rr_cpu;

   always_ff @(posedge clk) begin
      if (!rst)                  r_rr_cpu <= 1'b1;
      else if (w_gnt == GNT_CPU)  r_rr_cpu <= 1'b0;
      else if (w_gnt == GNT_FILL) r_rr_cpu <= 1'b1;
   end
`endif

   always_comb begin
      w_gnt = GNT_NONE;
      if (!bus.vram_stall) begin
         if (!w_empty && r_state == RUN) begin
`ifdef VRAM_ARB_RR_EN
            w_gnt = r_rr_cpu ? GNT_CPU : GNT_FILL;
`else
            w_gnt = GNT_CPU;
`endif
         end else if (!w_empty) begin
            w_gnt = GNT_CPU;
         end else if (r_state == RUN) begin
            w_gnt = GNT_FILL;
         end
      end
   end

   // Fill FSM next-state and counter updates.
   always_comb begin
      w_state_nxt      = r_state;
      w_fill_addr_nxt  = r_fill_addr;
      w_fill_rem_nxt   = r_fill_rem;
      w_fill_color_nxt = r_fill_color;
      w_fill_busy_nxt  = r_fill_busy;
      w_fill_done_nxt  = 1'b0;
      w_addr_inc       = {1'b0, r_fill_addr} + (VRAM_AW+1)'(1);
      unique case (r_state)
         IDLE: begin
            if (bus.fill_start) begin
               if (bus.fill_len != '0) begin
                  w_state_nxt      = RUN;
                  w_fill_addr_nxt  = bus.fill_base;
                  w_fill_rem_nxt   = bus.fill_len;
                  w_fill_color_nxt = bus.fill_color;
                  w_fill_busy_nxt  = 1'b1;
               end else begin
                  w_fill_done_nxt  = 1'b1;
               end
            end
         end
         RUN: begin
            if (w_gnt == GNT_FILL) begin
               w_fill_addr_nxt = (w_addr_inc >= (VRAM_AW+1)'(VRAM_WORDS))
                                 ? '0 : w_addr_inc[VRAM_AW-1:0];
               w_fill_rem_nxt  = r_fill_rem - VRAM_AW'(1);
               if (r_fill_rem == VRAM_AW'(1)) w_state_nxt = DONE;
            end
         end
         DONE: begin
            w_state_nxt     = IDLE;
            w_fill_busy_nxt = 1'b0;
            w_fill_done_nxt = 1'b1;
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state      <= IDLE;
         r_fill_addr  <= '0;
         r_fill_rem   <= '0;
         r_fill_color <= '0;
         r_fill_busy  <= 1'b0;
         r_fill_done  <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_fill_addr  <= w_fill_addr_nxt;
         r_fill_rem   <= w_fill_rem_nxt;
         r_fill_color <= w_fill_color_nxt;
         r_fill_busy  <= w_fill_busy_nxt;
         r_fill_done  <= w_fill_done_nxt;
      end
   end

   // Write port registers; addr/data hold when nothing is granted.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_vram_we   <= 1'b0;
         r_vram_addr <= '0;
         r_vram_data <= '0;
         r_wr_ovf    <= 1'b0;
      end else begin
         r_vram_we <= (w_gnt != GNT_NONE);
         unique case (w_gnt)
            GNT_CPU: begin
               r_vram_addr <= w_fifo_dout.addr;
               r_vram_data <= w_fifo_dout.data;
            end
            GNT_FILL: begin
               r_vram_addr <= r_fill_addr;
               r_vram_data <= r_fill_color;
            end
            default: ;
         endcase
         if (w_ovf_set)        r_wr_ovf <= 1'b1;
         else if (bus.ovf_clr) r_wr_ovf <= 1'b0;
      end
   end

   assign bus.cpu_ready = ~w_full;
   assign bus.fill_busy = r_fill_busy;
   assign bus.fill_done = r_fill_done;
   assign bus.wr_ovf    = r_wr_ovf;
   assign bus.vram_we   = r_vram_we;
   assign bus.vram_addr = r_vram_addr;
   assign bus.vram_data = r_vram_data;

endmodule
